elastic_pipe: RTL

Parametrised elastic pipeline register chain. It is the successor to the fixed enable-only pipeline registers between processor stages. It adds a valid/ready handshake, backpressure (stall), synchronous flush (bubble insertion) and an optional skid buffer per stage. It is placed between processor stages (IF/ID, ID/EX, EX/MEM, MEM/WB) or between memory ports, so that hazard logic can stall or squash without hand-wired enables.

---
 rtl/elastic_pipe_pkg.sv | 13 +
 rtl/elastic_stage.sv | 92 +++++++++
 rtl/elastic_pipe.sv | 87 ++++++++
 3 files changed

// File: rtl/elastic_pipe_pkg.sv
// Shared pipeline package: default payload/depth constants for the processor
// top and the occupancy-width helper used by elastic_pipe.
package elastic_pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_DEPTH  = 2;

    // Bits needed to count 0..depth*(skid+1) valid entries without wrapping.
    function automatic int unsigned occ_width(input int unsigned depth, input int unsigned skid);
        return $clog2(depth * (skid + 1) + 1);
    endfunction

endpackage

// File: rtl/elastic_stage.sv
// One elastic pipeline stage with valid/ready on both sides.
//   clk, arst_n     : clock, asynchronous active-low reset
//   enable          : 0 holds all state
//   flush           : clears stored entries on the next enabled edge
//   up_valid/up_data/up_ready_c : upstream side (up_ready_c is comb from state only)
//   down_valid/down_data/down_ready : downstream side (valid/data straight from main reg)
// SKID=1: main+skid registers, full throughput, ready depends only on skid_v.
// SKID=0: single register, ready = !main_v, one word per two cycles.
module elastic_stage #(
    parameter int unsigned DATA_W = 32,
    parameter bit          SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready_c,
    input  logic [DATA_W-1:0] up_data,
    output logic              down_valid,
    input  logic              down_ready,
    output logic [DATA_W-1:0] down_data
);

    logic              main_v;
    logic [DATA_W-1:0] main_d;
    logic              up_fire;
    logic              down_fire;

    assign up_fire    = up_valid & up_ready_c;
    assign down_fire  = main_v & down_ready;
    assign down_valid = main_v;
    assign down_data  = main_d;

    generate
        if (SKID) begin : g_skid
            logic              skid_v;
            logic [DATA_W-1:0] skid_d;

            assign up_ready_c = !skid_v;

            // Skid only fills while main is full and stalled, so main is never
            // empty while skid_v is set; a drain refills main from skid first.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    main_v <= 1'b0;
                    main_d <= '0;
                    skid_v <= 1'b0;
                    skid_d <= '0;
                end else if (enable) begin
                    if (flush) begin
                        main_v <= 1'b0;
                        skid_v <= 1'b0;
                    end else if (skid_v) begin
                        if (down_fire) begin
                            main_d <= skid_d;
                            skid_v <= 1'b0;
                        end
                    end else if (up_fire && (!main_v || down_fire)) begin
                        main_d <= up_data;
                        main_v <= 1'b1;
                    end else if (up_fire) begin
                        skid_d <= up_data;
                        skid_v <= 1'b1;
                    end else if (down_fire) begin
                        main_v <= 1'b0;
                    end
                end
            end
        end else begin : g_single
            assign up_ready_c = !main_v;

            // Accept and drain are mutually exclusive: ready is low while full.
            always_ff @(posedge clk or negedge arst_n) begin
                if (!arst_n) begin
                    main_v <= 1'b0;
                    main_d <= '0;
                end else if (enable) begin
                    if (flush) begin
                        main_v <= 1'b0;
                    end else if (up_fire) begin
                        main_d <= up_data;
                        main_v <= 1'b1;
                    end else if (down_fire) begin
                        main_v <= 1'b0;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/elastic_pipe.sv
// Elastic pipeline register chain of DEPTH elastic_stage instances with
// stall (enable), flush, occupancy count and sticky protocol-error flag.
//   clk, arst_n        : clock, asynchronous active-low reset
//   enable             : global run; 0 freezes state and masks in_ready/out_valid
//   flush              : squash all stored entries on the next edge
//   in_valid/in_ready/in_data    : upstream handshake (in_ready comb, no out_ready path)
//   out_valid/out_ready/out_data : downstream handshake from the last stage
//   occupancy          : registered count of valid entries
//   overflow_err       : sticky, set when in_valid is held against in_ready=0
module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter  int unsigned DATA_W = PIPE_DATA_W,
    parameter  int unsigned DEPTH  = PIPE_DEPTH,
    parameter  int unsigned SKID   = 1,
    localparam int unsigned CNT_W  = occ_width(DEPTH, SKID)
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              enable,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  occupancy,
    output logic              overflow_err
);

    // Element s is the upstream side of stage s; element DEPTH is the pipe output.
    logic [DEPTH:0]    v_chain;
    logic [DEPTH:0]    r_chain;
    logic [DATA_W-1:0] d_chain [DEPTH+1];
    logic              in_fire;
    logic              out_fire;

    assign v_chain[0]     = in_valid;
    assign d_chain[0]     = in_data;
    assign r_chain[DEPTH] = out_ready;

    generate
        for (genvar s = 0; s < DEPTH; s++) begin : g_stage
            elastic_stage #(
                .DATA_W (DATA_W),
                .SKID   (SKID != 0)
            ) u_stage (
                .clk        (clk),
                .arst_n     (arst_n),
                .enable     (enable),
                .flush      (flush),
                .up_valid   (v_chain[s]),
                .up_ready_c (r_chain[s]),
                .up_data    (d_chain[s]),
                .down_valid (v_chain[s+1]),
                .down_ready (r_chain[s+1]),
                .down_data  (d_chain[s+1])
            );
        end
    endgenerate

    // Reset gating keeps in_ready low while the chain is held in reset.
    assign in_ready  = enable & arst_n & r_chain[0];
    assign out_valid = enable & v_chain[DEPTH];
    assign out_data  = d_chain[DEPTH];
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Occupancy tracks transfers on the same edge the stage valid bits change.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            occupancy    <= '0;
            overflow_err <= 1'b0;
        end else if (enable) begin
            if (flush) begin
                occupancy <= '0;
            end else begin
                occupancy <= occupancy + CNT_W'(in_fire) - CNT_W'(out_fire);
            end
            if (in_valid && !in_ready && !flush) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule
